operand_pingpong_buf: RTL
=========================

OPERAND_PINGPONG_BUF -- requirements
Module: operand_pingpong_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one operand word.
REQ-002 SHALL have parameter DEPTH, default 10, words per bank (one row of the 10x10 array).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, write word offered.
REQ-006 SHALL have port in_ready, output, 1, write word accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data, input, DATA_WIDTH, write word.
REQ-008 SHALL have port out_valid, output, 1, read word available.
REQ-009 SHALL have port out_ready, input, 1, read word consumed when out_valid && out_ready.
REQ-010 SHALL have port out_data_a, output, DATA_WIDTH, bank A word at the read index; feeds mux inData_A.
REQ-011 SHALL have port out_data_b, output, DATA_WIDTH, bank B word at the read index; feeds mux inData_B.
REQ-012 SHALL have port out_sel, output, 1, read bank (0=A, 1=B); feeds mux sel.
REQ-013 SHALL have port out_last, output, 1, high with out_valid on read index DEPTH-1.

Function
REQ-014 Each bank SHALL run states EMPTY -> FILLING (first accepted write) -> FULL (DEPTH-th write) -> DRAINING (first consumed read) -> EMPTY (DEPTH-th read).
REQ-015 Write index SHALL count 0..DEPTH-1 per bank; on DEPTH-th write it SHALL wrap to 0 and write bank SHALL toggle.
REQ-016 in_ready SHALL be 1 iff write bank is EMPTY or FILLING; combinational from registered state only.
REQ-017 out_valid SHALL be 1 iff read bank is FULL or DRAINING; out_data_a/b SHALL be combinational reads at current read index (zero latency).
REQ-018 Read index SHALL count 0..DEPTH-1; on DEPTH-th consume it SHALL wrap to 0 and read bank SHALL toggle; out_sel SHALL equal read bank.
REQ-019 Same-cycle write completing one bank and read emptying the other SHALL both take effect; no cycle lost.
REQ-020 A bank SHALL not be written while FULL or DRAINING; write data with in_ready=0 SHALL be ignored.
REQ-021 Output data and out_sel SHALL hold while out_valid && !out_ready.
REQ-022 Sustained throughput SHALL be one word per cycle in and out once both banks are cycling.

Reset
REQ-023 On rst_n low, immediately: both banks EMPTY, write/read bank = A, indices 0, in_ready=1, out_valid=0, out_sel=0, out_last=0.
REQ-024 Bank contents SHALL reset to 0; out_data_a/b SHALL read 0 after reset.
REQ-025 Reset mid-fill or mid-drain SHALL discard partial rows; no word is emitted after deassertion until a full new row is written.

Configuration
REQ-026 With macro PPBUF_STALL_CNT_EN defined, SHALL add output stall_cnt (16 bits), counting cycles with in_valid && !in_ready, saturating at 16'hFFFF, reset to 0.
REQ-027 Without PPBUF_STALL_CNT_EN, port stall_cnt and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package pingpong_pkg SHALL hold the bank-state enumeration (EMPTY, FILLING, FULL, DRAINING) and default DATA_WIDTH/DEPTH constants.
REQ-029 One sub-module pp_bank SHALL implement one DEPTH x DATA_WIDTH register bank with write enable, write index, async read index; instantiated twice.

Verification
REQ-030 Reset then write 1..10 with out_ready=0 -> in_ready stays 1, after 10th write out_valid=1, out_sel=0, out_data_a=1.
REQ-031 Write 20 words (1..20), out_ready=0 -> 21st offer sees in_ready=0; stall_cnt increments per stalled cycle when macro defined.
REQ-032 Drain bank A with out_ready=1 -> out_data_a 1..10 on consecutive cycles, out_last high on 10th only, then out_sel=1, out_data_b=11.
REQ-033 Continuous in_valid=1/out_ready=1 streaming 100 words -> outputs in order, no bubbles after first row, in_ready never drops.
REQ-034 Assert rst_n low after 5 writes of a row -> out_valid=0, in_ready=1, indices 0; next 10 writes form a new row starting at out_data_a.
REQ-035 Random out_ready toggling -> output word and out_sel stable while stalled; scoreboard matches input order.

Source files
------------

// File: rtl/pingpong_pkg.sv
// ============================================================================
// Module : pingpong_pkg
// Brief  : Bank-state encoding, default sizes and helpers for the ping-pong buffer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pingpong_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 10;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Writes and reads never target the same bank in one cycle, so at most one
  // of wr/rd is meaningful for a given state.
  function automatic bank_state_t bank_next(input bank_state_t state,
                                            input logic wr, input logic wr_last,
                                            input logic rd, input logic rd_last);
    bank_state_t nxt;
    nxt = state;
    case (state)
      EMPTY:    if (wr) nxt = wr_last ? FULL : FILLING;
      FILLING:  if (wr && wr_last) nxt = FULL;
      FULL:     if (rd) nxt = rd_last ? EMPTY : DRAINING;
      DRAINING: if (rd && rd_last) nxt = EMPTY;
      default:  nxt = EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pp_bank.sv
// ============================================================================
// Module : pp_bank
// Brief  : DEPTH x DATA_WIDTH register bank, synchronous write, async read.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/operand_pingpong_buf.sv
// ============================================================================
// Module : operand_pingpong_buf
// Brief  : Two-bank row buffer; one bank fills while the other drains to the mux.
//          Optional macro PPBUF_STALL_CNT_EN adds a saturating write-stall counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_pingpong_buf
  import pingpong_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data_a,
  output logic [DATA_WIDTH-1:0] out_data_b,
  output logic                  out_sel,
  output logic                  out_last
`ifdef PPBUF_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int               IDX_W    = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  bank_state_t           r_state     [2];
  bank_state_t           w_state_nxt [2];
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [IDX_W-1:0]      r_wr_idx;
  logic [IDX_W-1:0]      r_rd_idx;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_wr_last;
  logic                  w_rd_last;
  logic [DATA_WIDTH-1:0] w_rd_data [2];

  assign in_ready  = (r_state[r_wr_bank] == EMPTY) || (r_state[r_wr_bank] == FILLING);
  assign out_valid = (r_state[r_rd_bank] == FULL)  || (r_state[r_rd_bank] == DRAINING);
  assign w_wr_fire = in_valid && in_ready;
  assign w_rd_fire = out_valid && out_ready;
  assign w_wr_last = (r_wr_idx == LAST_IDX);
  assign w_rd_last = (r_rd_idx == LAST_IDX);

  assign out_sel    = r_rd_bank;
  assign out_last   = out_valid && w_rd_last;
  assign out_data_a = w_rd_data[0];
  assign out_data_b = w_rd_data[1];

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = bank_next(r_state[b],
                                 w_wr_fire && (r_wr_bank == 1'(b)), w_wr_last,
                                 w_rd_fire && (r_rd_bank == 1'(b)), w_rd_last);
    end
  end

  // Write and read sides advance independently, so a row completing on one
  // bank and a row emptying on the other in the same cycle both take effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx  <= r_wr_idx + 1'b1;
        end
      end
      if (w_rd_fire) begin
        if (w_rd_last) begin
          r_rd_idx  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_idx  <= r_rd_idx + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    pp_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (w_wr_fire && (r_wr_bank == 1'(g))),
      .wr_idx  (r_wr_idx),
      .wr_data (in_data),
      .rd_idx  (r_rd_idx),
      .rd_data (w_rd_data[g])
    );
  end

`ifdef PPBUF_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !in_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
